// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        StFill,
        StEmit,
        StExtra
    } pad_state_e;

    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned LEN_WORD_HI = 14;
    localparam int unsigned LEN_WORD_LO = 15;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam logic [31:0] PAD_WORD_FULL = {PAD_BYTE, 24'h0};

    // Message bits carried by one accepted word; a final word may be partial (0 means 4 bytes).
    function automatic logic [5:0] word_bits(input logic last, input logic [1:0] bytes);
        if (last && bytes != 2'd0) begin
            return {1'b0, bytes, 3'b000};
        end
        return 6'd32;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks the unused bytes of a final word and inserts the 0x80 pad byte after the valid ones.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  bytes_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    always_comb begin
        word_o = data_i;
        full_o = 1'b0;
        unique case (bytes_i)
            2'd1:    word_o = {data_i[31:24], PAD_BYTE, 16'h0};
            2'd2:    word_o = {data_i[31:16], PAD_BYTE, 8'h0};
            2'd3:    word_o = {data_i[31:8], PAD_BYTE};
            default: full_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs 32-bit message words into padded 512-bit blocks.
// Optional SHA256_PADDER_ABORT_EN adds abort_i, a synchronous return to the reset state.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
`ifdef SHA256_PADDER_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    input  logic         in_last_i,
    input  logic [1:0]   in_bytes_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic [511:0] blk_data_o,
    output logic         blk_first_o,
    output logic         blk_last_o
);

    pad_state_e                         state_q;
    logic [3:0]                         idx_q;
    logic [LEN_WIDTH-1:0]               len_q;
    logic [BLOCK_WORDS-1:0][31:0]       buf_q;
    logic                               pending_q;
    logic                               carry_q;
    logic                               in_ready_q;
    logic                               blk_valid_q;
    logic                               blk_first_q;
    logic                               blk_last_q;

    logic [31:0]                        pad_word;
    logic                               pad_full;
    logic [4:0]                         pad_idx;
    logic                               pad_fits;
    logic                               accept;
    logic [LEN_WIDTH-1:0]               len_next;
    logic [63:0]                        len64_next;
    logic [63:0]                        len64_q;
    logic [BLOCK_WORDS-1:0][31:0]       last_blk;
    logic [BLOCK_WORDS-1:0][31:0]       extra_blk;

    sha256_pad_word u_pad_word (
        .data_i (in_data_i),
        .bytes_i(in_bytes_i),
        .word_o (pad_word),
        .full_o (pad_full)
    );

    assign accept     = in_valid_i && in_ready_q;
    assign len_next   = len_q + LEN_WIDTH'(word_bits(in_last_i, in_bytes_i));
    assign len64_next = 64'(len_next);
    assign len64_q    = 64'(len_q);
    // Index of the word that holds the 0x80 pad byte; 16 means it spills into an extra block.
    assign pad_idx    = {1'b0, idx_q} + {4'b0000, pad_full};
    assign pad_fits   = pad_idx < 5'(LEN_WORD_HI);

    always_comb begin
        last_blk = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (i < int'(idx_q)) begin
                last_blk[i] = buf_q[i];
            end else if (i == int'(idx_q)) begin
                last_blk[i] = pad_word;
            end else if (pad_full && i == int'(idx_q) + 1) begin
                last_blk[i] = PAD_WORD_FULL;
            end
        end
        if (pad_fits) begin
            last_blk[LEN_WORD_HI] = len64_next[63:32];
            last_blk[LEN_WORD_LO] = len64_next[31:0];
        end
    end

    always_comb begin
        extra_blk              = '0;
        extra_blk[0]           = carry_q ? PAD_WORD_FULL : 32'h0;
        extra_blk[LEN_WORD_HI] = len64_q[63:32];
        extra_blk[LEN_WORD_LO] = len64_q[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StFill;
            idx_q       <= '0;
            len_q       <= '0;
            buf_q       <= '0;
            pending_q   <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b1;
            blk_last_q  <= 1'b0;
        end
`ifdef SHA256_PADDER_ABORT_EN
        else if (abort_i) begin
            state_q     <= StFill;
            idx_q       <= '0;
            len_q       <= '0;
            buf_q       <= '0;
            pending_q   <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b1;
            blk_last_q  <= 1'b0;
        end
`endif
        else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        len_q <= len_next;
                        if (in_last_i) begin
                            buf_q      <= last_blk;
                            blk_last_q <= pad_fits;
                            pending_q  <= !pad_fits;
                            carry_q    <= pad_idx == 5'd16;
                        end else begin
                            buf_q[idx_q] <= in_data_i;
                            idx_q        <= idx_q + 4'd1;
                            blk_last_q   <= 1'b0;
                        end
                        if (in_last_i || idx_q == 4'd15) begin
                            state_q     <= StEmit;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (blk_ready_i) begin
                        blk_valid_q <= 1'b0;
                        blk_first_q <= blk_last_q;
                        if (pending_q) begin
                            state_q   <= StExtra;
                            pending_q <= 1'b0;
                        end else begin
                            state_q    <= StFill;
                            in_ready_q <= 1'b1;
                            idx_q      <= '0;
                            if (blk_last_q) begin
                                len_q <= '0;
                            end
                        end
                    end
                end
                StExtra: begin
                    buf_q       <= extra_blk;
                    carry_q     <= 1'b0;
                    blk_last_q  <= 1'b1;
                    blk_valid_q <= 1'b1;
                    state_q     <= StEmit;
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign blk_valid_o = blk_valid_q;
    assign blk_data_o  = buf_q;
    assign blk_first_o = blk_first_q;
    assign blk_last_o  = blk_last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder; blocks are captured as {data, first, last}.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA256_PADDER_ABORT_EN
    logic         abort = 1'b0;
`endif

    int chk = 0;
    int pass = 0;
    logic [513:0] cap_q[$];

    sha256_padder #(.LEN_WIDTH(64)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
`ifdef SHA256_PADDER_ABORT_EN
        .abort_i    (abort),
`endif
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .in_bytes_i (in_bytes),
        .blk_valid_o(blk_valid),
        .blk_ready_i(blk_ready),
        .blk_data_o (blk_data),
        .blk_first_o(blk_first),
        .blk_last_o (blk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (blk_valid && blk_ready) cap_q.push_back({blk_data, blk_first, blk_last});
    end

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk++;
        if (n >= 100) $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
        else pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int c;
        c = 0;
        while (cap_q.size() < n && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk++;
        if (cap_q.size() < n) $display("FAIL wait_blocks got %0d want %0d", cap_q.size(), n);
        else pass++;
    endtask

    function automatic logic [513:0] pop_blk();
        if (cap_q.size() == 0) return 'x;
        return cap_q.pop_front();
    endfunction

    function automatic logic [511:0] abc_blk();
        logic [511:0] e;
        e = '0;
        e[0 +: 32] = 32'h61626380;
        e[480 +: 32] = 32'h00000018;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk++;
        if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b1010)
            $display("FAIL reset_flags got %b want 1010", {in_ready, blk_valid, blk_first, blk_last});
        else pass++;
        chk++;
        if (blk_data !== '0) $display("FAIL reset_data got %h want 0", blk_data);
        else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_abc();
        logic [513:0] got;
        send(32'h61626300, 1'b1, 2'd3);
        chk++;
        if (blk_valid !== 1'b1) $display("FAIL abc_latency got valid=%b want 1", blk_valid);
        else pass++;
        wait_blocks(1);
        got = pop_blk();
        chk++;
        if (got !== {abc_blk(), 2'b11}) $display("FAIL abc_block got %h want %h", got, {abc_blk(), 2'b11});
        else pass++;
    endtask

    task automatic test_partial_full();
        logic [511:0] e;
        logic [513:0] got;
        send(32'h61FFFFFF, 1'b1, 2'd1);
        wait_blocks(1);
        e = '0; e[0 +: 32] = 32'h61800000; e[480 +: 32] = 32'd8;
        got = pop_blk();
        chk++;
        if (got !== {e, 2'b11}) $display("FAIL one_byte got %h want %h", got, {e, 2'b11});
        else pass++;
        send(32'hDEADBEEF, 1'b1, 2'd0);
        wait_blocks(1);
        e = '0; e[0 +: 32] = 32'hDEADBEEF; e[32 +: 32] = 32'h80000000; e[480 +: 32] = 32'd32;
        got = pop_blk();
        chk++;
        if (got !== {e, 2'b11}) $display("FAIL full_word got %h want %h", got, {e, 2'b11});
        else pass++;
    endtask

    task automatic test_fourteen();
        logic [511:0] ea, eb;
        logic [513:0] got;
        ea = '0;
        for (int i = 0; i < 14; i++) begin
            send({8'(i + 1), 24'hABCDEF}, i == 13, 2'd0);
            ea[32*i +: 32] = {8'(i + 1), 24'hABCDEF};
        end
        ea[448 +: 32] = 32'h80000000;
        eb = '0; eb[480 +: 32] = 32'h000001C0;
        wait_blocks(2);
        got = pop_blk();
        chk++;
        if (got !== {ea, 2'b10}) $display("FAIL w14_blockA got %h want %h", got, {ea, 2'b10});
        else pass++;
        got = pop_blk();
        chk++;
        if (got !== {eb, 2'b01}) $display("FAIL w14_blockB got %h want %h", got, {eb, 2'b01});
        else pass++;
    endtask

    task automatic test_sixteen();
        logic [511:0] ea, eb;
        logic [513:0] got;
        for (int i = 0; i < 16; i++) begin
            send(32'h11111111 * (i + 1), i == 15, 2'd0);
            ea[32*i +: 32] = 32'h11111111 * (i + 1);
        end
        eb = '0; eb[0 +: 32] = 32'h80000000; eb[480 +: 32] = 32'h00000200;
        wait_blocks(2);
        got = pop_blk();
        chk++;
        if (got !== {ea, 2'b10}) $display("FAIL w16_blockA got %h want %h", got, {ea, 2'b10});
        else pass++;
        got = pop_blk();
        chk++;
        if (got !== {eb, 2'b01}) $display("FAIL w16_blockB got %h want %h", got, {eb, 2'b01});
        else pass++;
    endtask

    task automatic test_seventeen();
        logic [511:0] ea, eb;
        logic [513:0] got;
        for (int i = 0; i < 16; i++) begin
            send(32'hC0000000 + i, 1'b0, 2'd0);
            ea[32*i +: 32] = 32'hC0000000 + i;
        end
        send(32'h12345678, 1'b1, 2'd2);
        eb = '0; eb[0 +: 32] = 32'h12348000; eb[480 +: 32] = 32'h00000210;
        wait_blocks(2);
        got = pop_blk();
        chk++;
        if (got !== {ea, 2'b10}) $display("FAIL w17_blockA got %h want %h", got, {ea, 2'b10});
        else pass++;
        got = pop_blk();
        chk++;
        if (got !== {eb, 2'b01}) $display("FAIL w17_blockB got %h want %h", got, {eb, 2'b01});
        else pass++;
    endtask

    task automatic test_stall();
        logic [513:0] got;
        logic [515:0] want;
        blk_ready = 1'b0;
        send(32'h61626300, 1'b1, 2'd3);
        want = {1'b1, abc_blk(), 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk++;
            if ({blk_valid, blk_data, blk_first, blk_last, in_ready} !== want)
                $display("FAIL stall_cycle%0d got %h want %h", k,
                         {blk_valid, blk_data, blk_first, blk_last, in_ready}, want);
            else pass++;
        end
        blk_ready = 1'b1;
        wait_blocks(1);
        got = pop_blk();
        chk++;
        if (got !== {abc_blk(), 2'b11}) $display("FAIL stall_block got %h want %h", got, {abc_blk(), 2'b11});
        else pass++;
    endtask

    task automatic test_reset_mid();
        logic [513:0] got;
        for (int i = 0; i < 7; i++) send(32'h5A5A0000 + i, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk++;
        if (cap_q.size() != 0) $display("FAIL reset_mid_drop got %0d blocks want 0", cap_q.size());
        else pass++;
        send(32'h61626300, 1'b1, 2'd3);
        wait_blocks(1);
        got = pop_blk();
        chk++;
        if (got !== {abc_blk(), 2'b11}) $display("FAIL reset_mid_abc got %h want %h", got, {abc_blk(), 2'b11});
        else pass++;
    endtask

`ifdef SHA256_PADDER_ABORT_EN
    task automatic test_abort();
        logic [513:0] got;
        for (int i = 0; i < 14; i++) send(32'hF0000000 + i, i == 13, 2'd0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk++;
        if ({cap_q.size() == 1, blk_valid} !== 2'b10)
            $display("FAIL abort_drop got blocks=%0d valid=%b want 1,0", cap_q.size(), blk_valid);
        else pass++;
        void'(pop_blk());
        send(32'h61626300, 1'b1, 2'd3);
        wait_blocks(1);
        got = pop_blk();
        chk++;
        if (got !== {abc_blk(), 2'b11}) $display("FAIL abort_restart got %h want %h", got, {abc_blk(), 2'b11});
        else pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_partial_full();
        test_fourteen();
        test_sixteen();
        test_seventeen();
        test_stall();
        test_reset_mid();
`ifdef SHA256_PADDER_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
